// File: rtl/ser_deser_rx.sv
// ser_deser_rx: serial-to-parallel receiver for the shift-register link.
// Frames a synced bit stream into WIDTH-bit words, MSB- or LSB-first.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ser_valid, ser_bit  serial bit and its qualifier
//   ser_sync            marks bit 0 of a word (qualified by ser_valid)
//   msb_first           bit order, sampled on the sync bit
//   out_valid/ready     word output handshake, out_data is the word
//   align_err, ovf_err  sticky error flags, cleared by err_clr
//   word_cnt            words loaded into the holding register (wraps)
module ser_deser_rx #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 4,
    parameter int WCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_valid,
    input  logic              ser_bit,
    input  logic              ser_sync,
    input  logic              msb_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              align_err,
    output logic              ovf_err,
    input  logic              err_clr,
    output logic [WCNT_W-1:0] word_cnt
);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t             state;
    logic [WIDTH-1:0]   sr;
    logic [CNT_W-1:0]   cnt;
    logic               mode;

    logic               take_sync;
    logic               take_bit;
    logic               restart;
    logic               last_bit;
    logic               accept;
    logic               m_eff;
    logic [WIDTH-1:0]   base;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        take_sync = ser_valid & ser_sync;
        take_bit  = ser_valid & (ser_sync | (state == COLLECT));
        // A sync while collecting discards the partial word, even
        // when it lands on what would have been the final bit.
        restart   = take_sync & (state == COLLECT);
        last_bit  = ser_valid & ~ser_sync & (state == COLLECT)
                  & (cnt == CNT_W'(WIDTH-1));
        // The sync bit uses the freshly sampled order and an empty
        // register so stale bits never leak into the new word.
        m_eff     = take_sync ? msb_first : mode;
        base      = take_sync ? '0 : sr;
        shifted   = m_eff ? {base[WIDTH-2:0], ser_bit}
                          : {ser_bit, base[WIDTH-1:1]};
        accept    = ~out_valid | out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            sr        <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            align_err <= 1'b0;
            ovf_err   <= 1'b0;
            word_cnt  <= '0;
        end else begin
            if (out_valid & out_ready)
                out_valid <= 1'b0;

            if (take_bit)
                sr <= shifted;

            if (take_sync) begin
                mode  <= msb_first;
                cnt   <= CNT_W'(1);
                state <= COLLECT;
            end else if (last_bit) begin
                cnt   <= '0;
                state <= HUNT;
                if (accept) begin
                    out_data  <= shifted;
                    out_valid <= 1'b1;
                    word_cnt  <= word_cnt + WCNT_W'(1);
                end
            end else if (take_bit) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Set events win over a simultaneous clear.
            align_err <= restart | (align_err & ~err_clr);
            ovf_err   <= (last_bit & ~accept) | (ovf_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_ser_deser_rx.sv
// tb_ser_deser_rx: vectors, corner sequences and a randomized run
// against a bit-list model of the receiver.
module tb_ser_deser_rx;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ser_valid, ser_bit, ser_sync, msb_first;
    logic        out_valid, out_ready, err_clr;
    logic [15:0] out_data;
    logic        align_err, ovf_err;
    logic [7:0]  word_cnt;

    int checks = 0;
    int errors = 0;

    ser_deser_rx dut (
        .clk(clk), .rst_n(rst_n),
        .ser_valid(ser_valid), .ser_bit(ser_bit),
        .ser_sync(ser_sync), .msb_first(msb_first),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .align_err(align_err),
        .ovf_err(ovf_err), .err_clr(err_clr),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b,
                         input logic s, input logic m);
        @(negedge clk);
        ser_valid = v;
        ser_bit   = b;
        ser_sync  = s;
        msb_first = m;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // seq[15] goes out first; order bit random off the sync bit.
    task automatic send_bits(input logic [15:0] seq, input int n,
                             input logic m, input bit sync,
                             input bit gap);
        for (int i = 0; i < n; i++) begin
            logic mm;
            mm = (i == 0) ? m : 1'($urandom);
            drive(1'b1, seq[15-i], sync && (i == 0), mm);
            if (gap && i < n - 1)
                drive(1'b0, 1'($urandom), 1'b0, 1'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        ser_valid = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        msb;
        logic [15:0] seq;
        logic [15:0] exp;
    } vec_t;

    // ---- behavioural model ----
    bit          m_inw;
    bit          m_mode;
    bit          m_bits[$];
    bit          m_hv;
    logic [15:0] m_hd;
    bit          m_al, m_ov;
    logic [7:0]  m_wc;

    function automatic logic [15:0] assemble(bit md);
        logic [15:0] w;
        w = '0;
        foreach (m_bits[i]) begin
            if (md) w[W-1-i] = m_bits[i];
            else    w[i]     = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_inw = 0; m_mode = 0; m_bits.delete();
        m_hv = 0; m_hd = '0; m_al = 0; m_ov = 0; m_wc = '0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit s,
                              input bit m, input bit rdy,
                              input bit clr);
        bit a_set, o_set, nhv;
        a_set = 0;
        o_set = 0;
        nhv   = (m_hv && rdy) ? 0 : m_hv;
        if (v && s) begin
            if (m_inw) a_set = 1;
            m_inw  = 1;
            m_mode = m;
            m_bits.delete();
            m_bits.push_back(b);
        end else if (v && m_inw) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                m_inw = 0;
                if (!m_hv || rdy) begin
                    m_hd = assemble(m_mode);
                    nhv  = 1;
                    m_wc = m_wc + 8'd1;
                end else begin
                    o_set = 1;
                end
                m_bits.delete();
            end
        end
        m_hv = nhv;
        m_al = a_set | (m_al & !clr);
        m_ov = o_set | (m_ov & !clr);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 16'hA5C3, 16'hA5C3};
        vecs[1] = '{1'b0, 16'hA5C3, 16'hC3A5};
        vecs[2] = '{1'b1, 16'h0001, 16'h0001};
        vecs[3] = '{1'b0, 16'h0001, 16'h8000};
        vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{1'b0, 16'h1234, 16'h2C48};

        rst_n = 1'b1; ser_valid = 0; ser_bit = 0; ser_sync = 0;
        msb_first = 0; out_ready = 1; err_clr = 0;
        do_reset();
        idle();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_align", 32'(align_err), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_wcnt", 32'(word_cnt), 0);

        // table vectors, one cycle output pulse
        foreach (vecs[i]) begin
            send_bits(vecs[i].seq, 16, vecs[i].msb, 1, 0);
            idle();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_data", i), 32'(out_data),
                32'(vecs[i].exp));
            chk($sformatf("vec%0d_wcnt", i), 32'(word_cnt), i + 1);
            idle();
            chk($sformatf("vec%0d_drop", i), 32'(out_valid), 0);
        end

        // overflow
        do_reset();
        out_ready = 0;
        send_bits(16'h1234, 16, 1, 1, 0);
        send_bits(16'hBEEF, 16, 1, 1, 0);
        idle();
        chk("ovf_data", 32'(out_data), 32'h1234);
        chk("ovf_flag", 32'(ovf_err), 1);
        chk("ovf_wcnt", 32'(word_cnt), 1);
        chk("ovf_hold", 32'(out_valid), 1);
        out_ready = 1;
        idle();
        chk("ovf_xfer", 32'(out_valid), 0);

        // alignment error, then clear
        do_reset();
        send_bits(16'hFFFF, 7, 1, 1, 0);
        send_bits(16'h00FF, 16, 1, 1, 0);
        idle();
        chk("al_flag", 32'(align_err), 1);
        chk("al_data", 32'(out_data), 32'h00FF);
        chk("al_valid", 32'(out_valid), 1);
        err_clr = 1;
        idle();
        err_clr = 0;
        chk("al_clr", 32'(align_err), 0);

        // gaps, then HUNT bits without sync
        do_reset();
        send_bits(16'h8001, 16, 1, 1, 1);
        idle();
        chk("gap_data", 32'(out_data), 32'h8001);
        chk("gap_valid", 32'(out_valid), 1);
        send_bits(16'hFFFF, 5, 1, 0, 0);
        idle();
        chk("hunt_none", 32'(out_valid), 0);
        chk("hunt_wcnt", 32'(word_cnt), 1);
        send_bits(16'h3C0F, 16, 1, 1, 0);
        idle();
        chk("hunt_next", 32'(out_data), 32'h3C0F);
        chk("hunt_flag", 32'(align_err), 0);

        // reset mid-word, asserted while bits keep arriving
        send_bits(16'hFFFF, 9, 1, 1, 0);
        @(negedge clk);
        rst_n = 0; ser_valid = 1; ser_sync = 1;
        @(negedge clk);
        rst_n = 1; ser_valid = 0; ser_sync = 0;
        send_bits(16'h5A5A, 16, 1, 1, 0);
        idle();
        chk("rmw_data", 32'(out_data), 32'h5A5A);
        chk("rmw_wcnt", 32'(word_cnt), 1);
        chk("rmw_flags", 32'({align_err, ovf_err}), 0);

        // word counter wrap
        do_reset();
        for (int k = 0; k < 256; k++)
            send_bits(16'(k * 7), 16, 1'(k), 1, 0);
        idle();
        chk("wrap_wcnt", 32'(word_cnt), 0);

        // randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            bit v, b, s, m, r, cl;
            @(negedge clk);
            chk("rnd_valid", 32'(out_valid), 32'(m_hv));
            chk("rnd_data", 32'(out_data), 32'(m_hd));
            chk("rnd_align", 32'(align_err), 32'(m_al));
            chk("rnd_ovf", 32'(ovf_err), 32'(m_ov));
            chk("rnd_wcnt", 32'(word_cnt), 32'(m_wc));
            v  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            s  = ($urandom_range(0, 24) == 0);
            m  = 1'($urandom);
            r  = ($urandom_range(0, 2) != 0);
            cl = ($urandom_range(0, 15) == 0);
            ser_valid = v; ser_bit = b; ser_sync = s;
            msb_first = m; out_ready = r; err_clr = cl;
            model_step(v, b, s, m, r, cl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
